// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM encodings and
// the minimum legal frame configuration.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_BUSY = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_e;

    localparam logic [15:0] DIV_MIN  = 16'd1;
    localparam logic [1:0]  STOP_MIN = 2'd1;

    // A zero divisor or zero stop-bit count would stall the transmitter.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d == 16'd0) ? DIV_MIN : d;
    endfunction

    function automatic logic [1:0] clamp_stop(input logic [1:0] s);
        return (s == 2'd0) ? STOP_MIN : s;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational rotate-priority picker: first active request strictly after
// last_grant, wrapping from N_REQ-1 back to 0.
module uart_rr_picker #(
    parameter  int N_REQ = 4,
    localparam int GNT_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GNT_W-1:0] last_grant,
    output logic             valid,
    output logic [GNT_W-1:0] winner
);

    logic [GNT_W-1:0] cursor;

    always_comb begin
        cursor = last_grant;
        valid  = 1'b0;
        winner = last_grant;
        for (int k = 0; k < N_REQ; k++) begin
            if (cursor == GNT_W'(N_REQ - 1)) begin
                cursor = '0;
            end else begin
                cursor = cursor + GNT_W'(1);
            end
            if (!valid && req[cursor]) begin
                valid  = 1'b1;
                winner = cursor;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte requesters.
// Optional UART_TX_ARB_BURST_EN lets the last grantee keep up to BURST_MAX re-grants.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ = 4,
`ifdef UART_TX_ARB_BURST_EN
    parameter  int BURST_MAX = 4,
`endif
    localparam int GNT_W = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_dat,
    output logic [N_REQ-1:0]     ack,
    input  logic [15:0]          cfg_divisor,
    input  logic [1:0]           cfg_stop_bits,
    input  logic                 cfg_bit_order,
    output logic                 tx_wr_ev,
    output logic [7:0]           tx_dat,
    output logic [15:0]          divisor,
    output logic [1:0]           stop_bit_num,
    output logic                 trans_bit_order,
    input  logic                 tx_ready,
    input  logic                 tx_done_ev,
    output logic [GNT_W-1:0]     grant_id,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output arb_state_e           dbg_state
);

    // Handshakes: requester i holds req[i] and its byte until the 1-cycle
    // ack[i], which coincides with tx_wr_ev. A frame is started only while
    // tx_ready is high; tx_ready falling then rising again brackets the frame.

    arb_state_e       state_q;
    logic             tx_wr_ev_q;
    logic [N_REQ-1:0] ack_q;
    logic [7:0]       tx_dat_q;
    logic             busy_q;
    logic [GNT_W-1:0] grant_q;
    logic [15:0]      div_q;
    logic [1:0]       stop_q;
    logic             order_q;
    logic [15:0]      frame_cnt_q;
    logic [15:0]      frame_cnt_d;

    logic             pick_valid;
    logic [GNT_W-1:0] pick_id;
    logic             win_valid;
    logic [GNT_W-1:0] win_id;
    logic [7:0]       win_dat;
    logic [N_REQ-1:0] win_onehot;
    logic             grant_now;

    uart_rr_picker #(
        .N_REQ(N_REQ)
    ) u_picker (
        .req        (req),
        .last_grant (grant_q),
        .valid      (pick_valid),
        .winner     (pick_id)
    );

`ifdef UART_TX_ARB_BURST_EN
    localparam int BURST_W = $clog2(BURST_MAX + 1);

    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] burst_d;
    logic               regrant;

    assign regrant   = req[grant_q] && (burst_q < BURST_W'(BURST_MAX));
    assign win_valid = regrant || pick_valid;
    assign win_id    = regrant ? grant_q : pick_id;

    // Count saturates when the search lands on the same requester again.
    always_comb begin
        burst_d = burst_q;
        if (grant_now) begin
            if (regrant) begin
                burst_d = burst_q + BURST_W'(1);
            end else if (pick_id != grant_q) begin
                burst_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign win_valid = pick_valid;
    assign win_id    = pick_id;
`endif

    assign grant_now  = (state_q == ARB_IDLE) && tx_ready && win_valid;
    assign win_dat    = req_dat[{win_id, 3'b000} +: 8];
    assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            tx_wr_ev_q <= 1'b0;
            ack_q      <= '0;
            tx_dat_q   <= '0;
            busy_q     <= 1'b0;
            grant_q    <= GNT_W'(N_REQ - 1);
            div_q      <= DIV_MIN;
            stop_q     <= STOP_MIN;
            order_q    <= 1'b0;
        end else begin
            tx_wr_ev_q <= 1'b0;
            ack_q      <= '0;
            case (state_q)
                ARB_IDLE: begin
                    // Config tracks the inputs only here; it freezes once a frame starts.
                    div_q   <= clamp_div(cfg_divisor);
                    stop_q  <= clamp_stop(cfg_stop_bits);
                    order_q <= cfg_bit_order;
                    if (grant_now) begin
                        tx_dat_q   <= win_dat;
                        grant_q    <= win_id;
                        tx_wr_ev_q <= 1'b1;
                        ack_q      <= win_onehot;
                        busy_q     <= 1'b1;
                        state_q    <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    state_q <= ARB_WAIT_BUSY;
                end
                ARB_WAIT_BUSY: begin
                    if (!tx_ready) begin
                        state_q <= ARB_WAIT_DONE;
                    end
                end
                ARB_WAIT_DONE: begin
                    if (tx_ready) begin
                        busy_q  <= 1'b0;
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign frame_cnt_d = tx_done_ev ? frame_cnt_q + 16'd1 : frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign ack             = ack_q;
    assign tx_wr_ev        = tx_wr_ev_q;
    assign tx_dat          = tx_dat_q;
    assign divisor         = div_q;
    assign stop_bit_num    = stop_q;
    assign trans_bit_order = order_q;
    assign grant_id        = grant_q;
    assign busy            = busy_q;
    assign frame_cnt       = frame_cnt_q;
    assign dbg_state       = state_q;

endmodule
